// File: rtl/ysyx_24070016_ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   IFU_RESET_PC : PC loaded on reset
//   IFU_NOP      : instruction word presented in place of a faulting fetch (addi x0,x0,0)
//   ifu_state_e  : fetch FSM states (REQ=0, WAIT=1, HOLD=2)
package ysyx_24070016_ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IFU_NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ysyx_24070016_ifu_pc.sv
// PC register and next-PC selection for the fetch unit.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   redirect_valid   : load redirect_pc (word aligned) this cycle
//   redirect_pc      : redirect target, low two bits ignored
//   advance          : step to the next sequential instruction (pc + 4)
//   pc               : current fetch PC
// Redirect outranks advance; with neither the PC holds.
module ysyx_24070016_ifu_pc
  import ysyx_24070016_ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (advance) begin
      // Natural wrap: 32'hFFFF_FFFC + 4 -> 0.
      pc_d = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/ysyx_24070016_ifu.sv
// Instruction fetch unit, directly upstream of the IDU.
// Issues one fetch at a time on a valid/ready instruction-memory bus, registers the
// returned word together with its PC, and offers {ifu_pc, ifu_inst, ifu_err} to the IDU
// with a valid/ready handshake. Redirects restart fetching at a new PC; a fetch already
// issued when a redirect arrives is marked with kill and its response is discarded.
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_req_addr : fetch request channel (word-aligned address)
//   imem_rsp_valid/ready, imem_rsp_data,
//   imem_rsp_err                        : fetch response channel, err = access fault
//   redirect_valid, redirect_pc         : one-cycle flush/restart from EXU/WBU
//   ifu_valid/ready, ifu_pc, ifu_inst,
//   ifu_err                             : instruction handed to the IDU
// Only XLEN = 32 is supported.
module ysyx_24070016_ifu
  import ysyx_24070016_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  output logic            imem_rsp_ready,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ifu_valid,
  input  logic            ifu_ready,
  output logic [XLEN-1:0] ifu_pc,
  output logic [XLEN-1:0] ifu_inst,
  output logic            ifu_err
);

  ifu_state_e      state_q, state_d;
  logic            kill_q, kill_d;
  logic            ifu_valid_q, ifu_valid_d;
  logic [XLEN-1:0] ifu_pc_q, ifu_pc_d;
  logic [XLEN-1:0] ifu_inst_q, ifu_inst_d;
  logic            ifu_err_q, ifu_err_d;

  logic [XLEN-1:0] pc;
  logic            pc_advance;
  logic            req_hs;
  logic            rsp_hs;

  ysyx_24070016_ifu_pc #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (pc_advance),
    .pc             (pc)
  );

  assign req_hs = (state_q == ST_REQ) && imem_req_ready;
  assign rsp_hs = (state_q == ST_WAIT) && imem_rsp_valid;

  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    ifu_valid_d = ifu_valid_q;
    ifu_pc_d    = ifu_pc_q;
    ifu_inst_d  = ifu_inst_q;
    ifu_err_d   = ifu_err_q;
    pc_advance  = 1'b0;

    unique case (state_q)
      ST_REQ: begin
        // The address may still change before the handshake; the slave samples it
        // only when accepting. A redirect on the accepting cycle makes this fetch stale.
        if (req_hs) begin
          state_d = ST_WAIT;
          if (redirect_valid) kill_d = 1'b1;
        end
      end

      ST_WAIT: begin
        if (rsp_hs) begin
          // Stale (killed) responses and responses overtaken by a same-cycle redirect
          // are dropped; either way the next fetch starts from the current pc.
          state_d = ST_REQ;
          kill_d  = 1'b0;
          if (!kill_q && !redirect_valid) begin
            ifu_valid_d = 1'b1;
            ifu_pc_d    = pc;
            ifu_err_d   = imem_rsp_err;
            ifu_inst_d  = imem_rsp_err ? IFU_NOP : imem_rsp_data;
            state_d     = ST_HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          ifu_valid_d = 1'b0;
          state_d     = ST_REQ;
        end else if (ifu_ready) begin
          ifu_valid_d = 1'b0;
          pc_advance  = 1'b1;
          state_d     = ST_REQ;
        end
      end

      default: begin
        state_d     = ST_REQ;
        kill_d      = 1'b0;
        ifu_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_REQ;
      kill_q      <= 1'b0;
      ifu_valid_q <= 1'b0;
      ifu_pc_q    <= '0;
      ifu_inst_q  <= '0;
      ifu_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      ifu_valid_q <= ifu_valid_d;
      ifu_pc_q    <= ifu_pc_d;
      ifu_inst_q  <= ifu_inst_d;
      ifu_err_q   <= ifu_err_d;
    end
  end

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_req_addr  = pc;
  assign imem_rsp_ready = (state_q == ST_WAIT);

  assign ifu_valid = ifu_valid_q;
  assign ifu_pc    = ifu_pc_q;
  assign ifu_inst  = ifu_inst_q;
  assign ifu_err   = ifu_err_q;

endmodule
